spi_frame_fsm: RTL and testbench
================================

Name: spi_frame_fsm

Overview:
Protocol engine directly downstream of the per-pin input conditioners: consumes conditioned chip-select, the SCLK edge pulses and conditioned MOSI.
Decodes SPI mode-0 frames of the form address/RW byte, then data byte.
Reads drive MISO from a byte-wide data memory; writes commit the data byte to that memory.
Sits between the conditioners and the data memory / MISO tri-state buffer.

Parameters:
DATAW, 8, frame byte width. Address byte = {addr[DATAW-2:0], rw}; rw=1 means read.
CNTW, 4, bit-counter width; must satisfy 2^CNTW > DATAW.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs_cond  in  1  conditioned chip select, active low
sclk_pos  in  1  one-clk pulse per SCLK rising edge
sclk_neg  in  1  one-clk pulse per SCLK falling edge
mosi_cond  in  1  conditioned MOSI
dm_dout  in  DATAW  memory read data; combinational from dm_addr
dm_addr  out  DATAW-1  memory address
dm_din  out  DATAW  memory write data
dm_we  out  1  memory write enable; one-clk pulse
miso  out  1  serial data out
miso_en  out  1  MISO buffer enable
frame_abort  out  1  one-clk pulse when CS deasserts mid-byte

Behaviour:
- Reset values, all registered outputs: dm_addr=0, dm_din=0, dm_we=0, miso=0, miso_en=0, frame_abort=0. On reset: state=IDLE, rx_sr=0, tx_sr=0, bitcnt=0.
- SCLK timing requirement: each SCLK half-period is at least 8 clk cycles. This guarantees that DECODE and READ_LOAD complete between SCLK edges.
- Shifting is MSB first. rx_sr shifts in mosi_cond on each sclk_pos in the receive states; bitcnt counts the sclk_pos pulses.
- IDLE: cs_cond=0 -> GET_ADDR, with bitcnt=0.
- GET_ADDR: shift on sclk_pos. The clk that sees the DATAW-th sclk_pos goes to DECODE.
- DECODE (1 clk): dm_addr<=rx_sr[DATAW-1:1]; bitcnt<=0. rx_sr[0]=1 -> READ_LOAD, else WRITE_GET.
- READ_LOAD (1 clk): tx_sr<=dm_dout; miso_en<=1 -> READ_SHIFT.
  - miso = tx_sr[DATAW-1], registered, so the data MSB is valid before the first data sclk_pos.
- READ_SHIFT: bitcnt counts sclk_pos.
  - On sclk_neg with bitcnt>0, tx_sr shifts left (zero fill) and miso updates.
  - The sclk_neg that closes the address byte (bitcnt=0) is ignored.
  - The clk that sees the DATAW-th sclk_pos goes to DONE.
- WRITE_GET: shift on sclk_pos. The DATAW-th sclk_pos goes to WRITE_COMMIT.
- WRITE_COMMIT (1 clk): dm_din<=rx_sr, dm_we=1 registered, so dm_din and dm_we are valid in the same clk -> DONE.
- DONE: miso_en<=0 and all SCLK pulses are ignored. cs_cond=1 -> IDLE.
- Chip-select deassertion: cs_cond=1 in any state other than IDLE or DONE -> IDLE on the next clk, with miso_en<=0.
  - frame_abort pulses if bitcnt!=0, or if the state is DECODE, READ_LOAD or WRITE_COMMIT.
  - A partial write never asserts dm_we.
  - A WRITE_COMMIT already in progress completes.
- Simultaneous sclk_pos and cs_cond=1: cs_cond wins; no shift is taken.
- The bit counter resets at every byte boundary and never wraps within a byte.

Optional Feature:
Macro: SPI_BURST_EN.
- Defined:
  - Read burst: after the DATAW-th data sclk_pos in READ_SHIFT, dm_addr<=dm_addr+1 (wraps modulo 2^(DATAW-1)) and bitcnt<=0, then READ_LOAD. Each further byte streams the next location.
  - Write burst: WRITE_COMMIT increments dm_addr the clk after dm_we, then WRITE_GET.
  - The burst ends only on cs_cond=1. A partial burst byte raises frame_abort; bytes already committed stay committed.
- Undefined: exactly one data byte per frame, then DONE; dm_addr never increments.

Test Plan:
- Write 0x0A<-0x5A: CS low, MOSI 0x14 then 0x5A, CS high -> one dm_we pulse with dm_addr=0x0A, dm_din=0x5A; frame_abort stays 0.
- Read 0x0A with dm_dout=0xC3: MOSI 0x15 then 8 clocks -> miso_en=1 from READ_LOAD; bits sampled at sclk_pos are 1,1,0,0,0,0,1,1; miso_en=0 in DONE.
- Abort: CS rises after 3 data bits of a write to 0x05 -> frame_abort=1 for one clk, no dm_we, state IDLE; next full frame works.
- rst_n low mid-read-shift -> all outputs 0 immediately, asynchronously; after release, stays IDLE until cs_cond falls.
- SPI_BURST_EN, address byte 0xFF (read from 0x7F), 2 data bytes -> dm_addr goes 0x7F then 0x00; miso streams mem[0x7F] then mem[0x00].
- Without the macro, 2 data bytes after a write to 0x03 -> exactly one dm_we, with dm_din = first byte.

Source files
------------

// File: rtl/spi_frame_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_fsm
//  Purpose  : SPI mode-0 slave protocol engine. Decodes frames made of an
//             address/RW byte ({addr[DATAW-2:0], rw}, rw=1 is a read)
//             followed by a data byte. Reads stream a byte from the data
//             memory out on MISO; writes commit the received byte to it.
//  Ports    : clk, rst_n          - system clock, async active-low reset
//             cs_cond             - conditioned chip select (active low)
//             sclk_pos/sclk_neg   - one-clk pulses per SCLK rising/falling edge
//             mosi_cond           - conditioned MOSI
//             dm_dout             - memory read data (combinational on dm_addr)
//             dm_addr/dm_din/dm_we- memory address, write data, write strobe
//             miso/miso_en        - serial data out and its buffer enable
//             frame_abort         - pulse when CS rises part-way through a byte
//  Options  : SPI_BURST_EN - when defined, reads and writes keep streaming
//             consecutive addresses until chip select rises.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_frame_fsm #(
  parameter int DATAW = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_cond,
  input  logic             sclk_pos,
  input  logic             sclk_neg,
  input  logic             mosi_cond,
  input  logic [DATAW-1:0] dm_dout,
  output logic [DATAW-2:0] dm_addr,
  output logic [DATAW-1:0] dm_din,
  output logic             dm_we,
  output logic             miso,
  output logic             miso_en,
  output logic             frame_abort
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    DECODE       = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_GET    = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_t;

  // Count value at which the final bit of a byte is being taken.
  localparam logic [CNTW-1:0] c_last_bit = CNTW'(DATAW - 1);
  localparam logic [DATAW-2:0] c_addr_one = {{(DATAW-2){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DATAW-1:0] rx_sr_q, rx_sr_d;
  logic [DATAW-1:0] tx_sr_q, tx_sr_d;
  logic [CNTW-1:0]  bitcnt_q, bitcnt_d;
  logic [DATAW-2:0] dm_addr_q, dm_addr_d;
  logic [DATAW-1:0] dm_din_q, dm_din_d;
  logic             dm_we_q, dm_we_d;
  logic             miso_q, miso_d;
  logic             miso_en_q, miso_en_d;
  logic             frame_abort_q, frame_abort_d;

  logic [DATAW-1:0] w_rx_next;
  logic             w_cs_drop;

  assign w_rx_next = {rx_sr_q[DATAW-2:0], mosi_cond};
  // CS rising is only an event while a frame is actually in progress.
  assign w_cs_drop = cs_cond && (state_q != IDLE) && (state_q != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      bitcnt_q      <= '0;
      dm_addr_q     <= '0;
      dm_din_q      <= '0;
      dm_we_q       <= 1'b0;
      miso_q        <= 1'b0;
      miso_en_q     <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      bitcnt_q      <= bitcnt_d;
      dm_addr_q     <= dm_addr_d;
      dm_din_q      <= dm_din_d;
      dm_we_q       <= dm_we_d;
      miso_q        <= miso_d;
      miso_en_q     <= miso_en_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    bitcnt_d      = bitcnt_q;
    dm_addr_d     = dm_addr_q;
    dm_din_d      = dm_din_q;
    dm_we_d       = 1'b0;
    miso_d        = miso_q;
    miso_en_d     = miso_en_q;
    frame_abort_d = 1'b0;

    if (w_cs_drop) begin
      // Chip select wins over any coincident SCLK pulse.
      state_d       = IDLE;
      miso_en_d     = 1'b0;
      bitcnt_d      = '0;
      frame_abort_d = (bitcnt_q != '0) || (state_q == DECODE) ||
                      (state_q == READ_LOAD) || (state_q == WRITE_COMMIT);
      // A fully received byte already in commit still reaches memory.
      if (state_q == WRITE_COMMIT) begin
        dm_din_d = rx_sr_q;
        dm_we_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!cs_cond) begin
            state_d  = GET_ADDR;
            bitcnt_d = '0;
          end
        end

        GET_ADDR: begin
          if (sclk_pos) begin
            rx_sr_d = w_rx_next;
            if (bitcnt_q == c_last_bit) begin
              bitcnt_d = '0;
              state_d  = DECODE;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end

        DECODE: begin
          dm_addr_d = rx_sr_q[DATAW-1:1];
          bitcnt_d  = '0;
          state_d   = rx_sr_q[0] ? READ_LOAD : WRITE_GET;
        end

        READ_LOAD: begin
          // miso mirrors the tx MSB so bit DATAW-1 is on the wire before
          // the first data sclk_pos.
          tx_sr_d   = dm_dout;
          miso_d    = dm_dout[DATAW-1];
          miso_en_d = 1'b1;
          state_d   = READ_SHIFT;
        end

        READ_SHIFT: begin
          if (sclk_pos) begin
            if (bitcnt_q == c_last_bit) begin
              bitcnt_d = '0;
`ifdef SPI_BURST_EN
              dm_addr_d = dm_addr_q + c_addr_one;
              state_d   = READ_LOAD;
`else
              state_d   = DONE;
`endif
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end else if (sclk_neg && (bitcnt_q != '0)) begin
            // The falling edge that closes the previous byte (count 0) must
            // not disturb the freshly loaded MSB.
            tx_sr_d = {tx_sr_q[DATAW-2:0], 1'b0};
            miso_d  = tx_sr_q[DATAW-2];
          end
        end

        WRITE_GET: begin
          if (sclk_pos) begin
            rx_sr_d = w_rx_next;
            if (bitcnt_q == c_last_bit) begin
              bitcnt_d = '0;
              state_d  = WRITE_COMMIT;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end

        WRITE_COMMIT: begin
          dm_din_d = rx_sr_q;
          dm_we_d  = 1'b1;
`ifdef SPI_BURST_EN
          state_d  = WRITE_GET;
`else
          state_d  = DONE;
`endif
        end

        DONE: begin
          miso_en_d = 1'b0;
          if (cs_cond) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

`ifdef SPI_BURST_EN
    // Advance the write address once the strobe has been seen by memory,
    // so dm_addr is stable for the whole dm_we cycle.
    if (dm_we_q) begin
      dm_addr_d = dm_addr_q + c_addr_one;
    end
`endif
  end

  assign dm_addr     = dm_addr_q;
  assign dm_din      = dm_din_q;
  assign dm_we       = dm_we_q;
  assign miso        = miso_q;
  assign miso_en     = miso_en_q;
  assign frame_abort = frame_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_fsm
//  Purpose  : Directed self-checking bench for spi_frame_fsm. Drives SCLK
//             edge pulses with 8-clk half periods and a behavioural byte
//             memory on the dm_* port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_fsm;

  localparam int DATAW = 8;
  localparam int CNTW  = 4;

  logic             clk;
  logic             rst_n;
  logic             cs_cond;
  logic             sclk_pos;
  logic             sclk_neg;
  logic             mosi_cond;
  logic [DATAW-1:0] dm_dout;
  logic [DATAW-2:0] dm_addr;
  logic [DATAW-1:0] dm_din;
  logic             dm_we;
  logic             miso;
  logic             miso_en;
  logic             frame_abort;

  logic [DATAW-1:0] mem [0:(1<<(DATAW-1))-1];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int abort_cnt = 0;
  logic [DATAW-2:0] last_addr = '0;
  logic [DATAW-1:0] last_din  = '0;

  spi_frame_fsm #(.DATAW(DATAW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_cond     (cs_cond),
    .sclk_pos    (sclk_pos),
    .sclk_neg    (sclk_neg),
    .mosi_cond   (mosi_cond),
    .dm_dout     (dm_dout),
    .dm_addr     (dm_addr),
    .dm_din      (dm_din),
    .dm_we       (dm_we),
    .miso        (miso),
    .miso_en     (miso_en),
    .frame_abort (frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
  end

  always @(negedge clk) begin
    if (dm_we) begin
      we_cnt    = we_cnt + 1;
      last_addr = dm_addr;
      last_din  = dm_din;
    end
    if (frame_abort) abort_cnt = abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the top n bits of tx MSB first; rx collects miso as sampled at
  // each rising SCLK edge.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi_cond = tx[7-i];
      tick(8);
      rx[7-i] = miso;
      sclk_pos = 1'b1;
      tick(1);
      sclk_pos = 1'b0;
      tick(8);
      sclk_neg = 1'b1;
      tick(1);
      sclk_neg = 1'b0;
    end
  endtask

  task automatic cs_low;
    cs_cond = 1'b0;
    tick(4);
  endtask

  task automatic cs_high;
    tick(4);
    cs_cond = 1'b1;
    tick(4);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    logic [7:0] rx;
    cs_low();
    spi_bits({addr, 1'b0}, 8, rx);
    spi_bits(data, 8, rx);
    cs_high();
  endtask

  logic [7:0] rx;
  int we0, ab0;

  initial begin
    rst_n = 1'b0; cs_cond = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; mosi_cond = 1'b0;
    tick(3);
    check("reset_outputs", {dm_addr, dm_din, dm_we, miso, miso_en, frame_abort}, 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Write 0x0A <- 0x5A
    we0 = we_cnt; ab0 = abort_cnt;
    spi_write(7'h0A, 8'h5A);
    check("wr_we_count", we_cnt - we0, 1);
    check("wr_addr", last_addr, 32'h0A);
    check("wr_din", last_din, 32'h5A);
    check("wr_no_abort", abort_cnt - ab0, 0);
    check("wr_mem", mem[7'h0A], 32'h5A);

    // Read 0x0A holding 0xC3
    spi_write(7'h0A, 8'hC3);
    cs_low();
    spi_bits(8'h15, 8, rx);
    check("rd_miso_en_on", miso_en, 1);
    check("rd_addr", dm_addr, 32'h0A);
    spi_bits(8'h00, 8, rx);
    check("rd_data", rx, 32'hC3);
    check("rd_miso_en_done", miso_en, 0);
    cs_high();

    // Abort: CS rises after 3 data bits of a write to 0x05
    we0 = we_cnt; ab0 = abort_cnt;
    cs_low();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'hFF, 3, rx);
    cs_cond = 1'b1;
    tick(4);
    check("abort_pulse", abort_cnt - ab0, 1);
    check("abort_no_we", we_cnt - we0, 0);
    spi_write(7'h05, 8'h3C);
    check("after_abort_we", we_cnt - we0, 1);
    check("after_abort_din", last_din, 32'h3C);
    check("after_abort_addr", last_addr, 32'h05);

    // Asynchronous reset mid read-shift
    cs_low();
    spi_bits(8'h15, 8, rx);
    spi_bits(8'h00, 3, rx);
    check("rst_partial_rd", rx, 32'hC0);
    check("rst_pre_miso_en", miso_en, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", {dm_addr, dm_din, dm_we, miso, miso_en, frame_abort}, 32'h0);
    cs_cond = 1'b1;
    tick(3);
    rst_n = 1'b1;
    we0 = we_cnt; ab0 = abort_cnt;
    spi_bits(8'h15, 8, rx);
    check("idle_hold_miso_en", miso_en, 0);
    check("idle_hold_addr", dm_addr, 32'h0);
    check("idle_hold_we", we_cnt - we0, 0);
    check("idle_hold_abort", abort_cnt - ab0, 0);
    cs_low();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    check("post_rst_read", rx, 32'h3C);
    cs_high();

    // Write to 0x03 with two data bytes
    we0 = we_cnt; ab0 = abort_cnt;
    cs_low();
    spi_bits(8'h06, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    cs_high();
    check("two_byte_mem3", mem[7'h03], 32'h11);
    check("two_byte_abort", abort_cnt - ab0, 0);
`ifdef SPI_BURST_EN
    check("two_byte_we", we_cnt - we0, 2);
    check("two_byte_mem4", mem[7'h04], 32'h22);
`else
    check("two_byte_we", we_cnt - we0, 1);
    check("two_byte_addr", dm_addr, 32'h03);
`endif

    // Read from 0x7F (address byte 0xFF), two data bytes
    spi_write(7'h7F, 8'hA5);
    spi_write(7'h00, 8'h5C);
    cs_low();
    spi_bits(8'hFF, 8, rx);
    check("rd7f_addr", dm_addr, 32'h7F);
    spi_bits(8'h00, 8, rx);
    check("rd7f_byte0", rx, 32'hA5);
`ifdef SPI_BURST_EN
    check("rd7f_wrap_addr", dm_addr, 32'h00);
    spi_bits(8'h00, 8, rx);
    check("rd7f_byte1", rx, 32'h5C);
`else
    check("rd7f_addr_hold", dm_addr, 32'h7F);
`endif
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
